// File: rtl/control_pins_sync_if.sv
// Pin-side and core-side signal bundle for control_pins_sync; slave = the sync block, master = its driver.
// CTL_PINS_INT_LATCH_EN adds the intr_ack input.
interface control_pins_sync_if #(
   parameter int INT_CH = 1
);
   logic              pin_nWAIT;
   logic [INT_CH-1:0] pin_nINT;
   logic              pin_nNMI;
   logic              pin_nRESET;
   logic              pin_nBUSRQ;
   logic              busack;
   logic              nmi_ack;
   logic              wait_start;
`ifdef CTL_PINS_INT_LATCH_EN
   logic              intr_ack;
`endif
   logic              reset_in;
   logic              intr;
   logic [INT_CH-1:0] intr_src;
   logic              nmi;
   logic              busrq;
   logic              mwait;
   logic              pin_control_oe;
   logic              pin_nBUSACK;

`ifdef CTL_PINS_INT_LATCH_EN
   modport slave (
      input  pin_nWAIT, pin_nINT, pin_nNMI, pin_nRESET, pin_nBUSRQ,
      input  busack, nmi_ack, wait_start, intr_ack,
      output reset_in, intr, intr_src, nmi, busrq, mwait, pin_control_oe, pin_nBUSACK
   );
   modport master (
      output pin_nWAIT, pin_nINT, pin_nNMI, pin_nRESET, pin_nBUSRQ,
      output busack, nmi_ack, wait_start, intr_ack,
      input  reset_in, intr, intr_src, nmi, busrq, mwait, pin_control_oe, pin_nBUSACK
   );
`else
   modport slave (
      input  pin_nWAIT, pin_nINT, pin_nNMI, pin_nRESET, pin_nBUSRQ,
      input  busack, nmi_ack, wait_start,
      output reset_in, intr, intr_src, nmi, busrq, mwait, pin_control_oe, pin_nBUSACK
   );
   modport master (
      output pin_nWAIT, pin_nINT, pin_nNMI, pin_nRESET, pin_nBUSRQ,
      output busack, nmi_ack, wait_start,
      input  reset_in, intr, intr_src, nmi, busrq, mwait, pin_control_oe, pin_nBUSACK
   );
`endif
endinterface

// File: rtl/control_pins_sync.sv
// Z80 control-pin front end: pin synchroniser, reset filter/stretcher, NMI edge latch, interrupts,
// auto wait states and bus-release FSM. All outputs registered, SYNC_STAGES+1 cycles pin-to-output. Macro CTL_PINS_INT_LATCH_EN makes intr sticky.
module control_pins_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int INT_CH      = 1,
   parameter int RESET_FILT  = 3,
   parameter int RESET_HOLD  = 4,
   parameter int AUTO_WAIT   = 0,
   parameter int TURNAROUND  = 1
) (
   input logic                 i_clk,
   input logic                 i_reset,
   control_pins_sync_if.slave  bus
);
   localparam int NP  = INT_CH + 4;
   localparam int FCW = $clog2(RESET_FILT + 1);
   localparam int HCW = $clog2(RESET_HOLD + 1);
   localparam int WCW = (AUTO_WAIT > 0) ? $clog2(AUTO_WAIT + 1) : 1;
   localparam int TCW = $clog2(TURNAROUND + 1);

   typedef enum logic [1:0] {ST_RELEASE, ST_OWN, ST_GRANT, ST_TURN} bus_st_t;

   logic [NP-1:0]     w_pins;
   logic [NP-1:0]     w_sync;
   logic [NP-1:0]     r_sync [SYNC_STAGES];
   logic [INT_CH-1:0] w_int_act;
   logic [INT_CH-1:0] w_int_lo;
   logic              w_nwait_s, w_nnmi_s, w_nreset_s, w_nbusrq_s;
   logic [FCW-1:0]    r_filt;
   logic [HCW-1:0]    r_hold;
   logic              r_reset_in;
   logic              r_nmi_prev, r_nmi;
   logic              r_intr;
   logic [INT_CH-1:0] r_intr_src;
   logic              r_busrq;
   logic [WCW-1:0]    r_wcnt, w_wcnt_nxt;
   logic              r_mwait;
   bus_st_t           r_st;
   logic [TCW-1:0]    r_tcnt;
   logic              r_oe, r_nbusack;

   assign w_pins     = {bus.pin_nBUSRQ, bus.pin_nRESET, bus.pin_nNMI, bus.pin_nWAIT, bus.pin_nINT};
   assign w_sync     = r_sync[SYNC_STAGES-1];
   assign w_nwait_s  = w_sync[INT_CH];
   assign w_nnmi_s   = w_sync[INT_CH+1];
   assign w_nreset_s = w_sync[INT_CH+2];
   assign w_nbusrq_s = w_sync[INT_CH+3];
   assign w_int_act  = ~w_sync[INT_CH-1:0];
   // Isolate the lowest set bit: x & -x.
   assign w_int_lo   = w_int_act & (~w_int_act + INT_CH'(1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
      end else begin
         r_sync[0] <= w_pins;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   // Low pulses shorter than RESET_FILT never reach the core; hold pauses while low but unaccepted.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_filt     <= '0;
         r_hold     <= HCW'(RESET_HOLD);
         r_reset_in <= 1'b1;
      end else if (!w_nreset_s) begin
         if (r_filt != FCW'(RESET_FILT)) r_filt <= r_filt + FCW'(1);
         if (r_filt >= FCW'(RESET_FILT - 1)) begin
            r_reset_in <= 1'b1;
            r_hold     <= HCW'(RESET_HOLD);
         end
      end else begin
         r_filt <= '0;
         if (r_hold != '0) begin
            r_hold <= r_hold - HCW'(1);
            if (r_hold == HCW'(1)) r_reset_in <= 1'b0;
         end
      end
   end

   // A new edge beats a simultaneous ack so no NMI is lost.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_nmi_prev <= 1'b1;
         r_nmi      <= 1'b0;
      end else begin
         r_nmi_prev <= w_nnmi_s;
         if (r_reset_in)                  r_nmi <= 1'b0;
         else if (r_nmi_prev && !w_nnmi_s) r_nmi <= 1'b1;
         else if (bus.nmi_ack)            r_nmi <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_intr     <= 1'b0;
         r_intr_src <= '0;
         r_busrq    <= 1'b0;
      end else begin
         r_busrq <= ~w_nbusrq_s;
`ifdef CTL_PINS_INT_LATCH_EN
         if (r_reset_in || (r_intr && bus.intr_ack)) begin
            r_intr     <= 1'b0;
            r_intr_src <= '0;
         end else if (!r_intr) begin
            r_intr     <= |w_int_act;
            r_intr_src <= w_int_lo;
         end
`else
         r_intr     <= |w_int_act;
         r_intr_src <= w_int_lo;
`endif
      end
   end

   always_comb begin
      w_wcnt_nxt = r_wcnt;
      if (r_reset_in)           w_wcnt_nxt = '0;
      else if (bus.wait_start)  w_wcnt_nxt = WCW'(AUTO_WAIT);
      else if (r_wcnt != '0)    w_wcnt_nxt = r_wcnt - WCW'(1);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wcnt  <= '0;
         r_mwait <= 1'b0;
      end else begin
         r_wcnt  <= w_wcnt_nxt;
         r_mwait <= ~w_nwait_s | (w_wcnt_nxt != '0);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_st      <= ST_RELEASE;
         r_tcnt    <= '0;
         r_oe      <= 1'b0;
         r_nbusack <= 1'b1;
      end else if (r_reset_in) begin
         r_st      <= ST_RELEASE;
         r_oe      <= 1'b0;
         r_nbusack <= 1'b1;
      end else begin
         case (r_st)
            ST_RELEASE: begin
               r_st <= ST_OWN;
               r_oe <= 1'b1;
            end
            ST_OWN: if (bus.busack) begin
               r_st      <= ST_GRANT;
               r_oe      <= 1'b0;
               r_nbusack <= 1'b0;
            end
            ST_GRANT: if (!bus.busack) begin
               r_st      <= ST_TURN;
               r_tcnt    <= TCW'(TURNAROUND);
               r_nbusack <= 1'b1;
            end
            ST_TURN: begin
               if (bus.busack) begin
                  r_st      <= ST_GRANT;
                  r_nbusack <= 1'b0;
               end else if (r_tcnt == TCW'(1)) begin
                  r_st <= ST_OWN;
                  r_oe <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt - TCW'(1);
               end
            end
            default: r_st <= ST_RELEASE;
         endcase
      end
   end

   assign bus.reset_in       = r_reset_in;
   assign bus.intr           = r_intr;
   assign bus.intr_src       = r_intr_src;
   assign bus.nmi            = r_nmi;
   assign bus.busrq          = r_busrq;
   assign bus.mwait          = r_mwait;
   assign bus.pin_control_oe = r_oe;
   assign bus.pin_nBUSACK    = r_nbusack;
endmodule
